// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared definitions for the data-memory arbiter slice: default geometry of
// the vector data memory, the packed vector word type, requester identities
// and a few small helpers used by the arbiter and its interface.
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

    // Default data-memory geometry
    localparam int DEF_ADDR_W    = 17;
    localparam int DEF_LANES     = 6;
    localparam int DEF_LANE_W    = 8;
    localparam int DEF_DMEM_SIZE = 10926;   // highest valid word address

    localparam int DEF_WORD_W = DEF_LANES * DEF_LANE_W;

    // Number of requesters sharing the data memory
    localparam int NREQ = 2;

    // One data-memory word: LANES lanes of LANE_W bits, lane 0 in the LSBs
    typedef logic [DEF_LANES-1:0][DEF_LANE_W-1:0] word_t;

    // Requester identities
    typedef enum logic {
        REQ_LSU    = 1'b0,      // vector CPU load/store unit
        REQ_LOADER = 1'b1       // external loader
    } req_id_t;

    // One-hot response vector for a requester id
    function automatic logic [NREQ-1:0] id_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles both requester ports and the data-memory port of the arbiter.
//   req_i/we_i/addr_i/wdata_i [r] : requests from requester r (0=LSU, 1=loader)
//   gnt_o/done_o/err_o [r]        : accept, completion pulse, range error
//   rdata_o                       : read vector, valid with a read's done_o
//   mem_we_o/mem_addr_o/mem_wd_o  : data-memory write/address/write data
//   mem_rd_i                      : data-memory combinational read data
// slave  : the arbiter side
// master : requesters plus data memory (environment side)
// -----------------------------------------------------------------------------
interface dmem_arbiter_if
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LANES  = DEF_LANES,
    parameter int LANE_W = DEF_LANE_W
) ();

    localparam int WORD_W = LANES * LANE_W;

    // Requester side
    logic [NREQ-1:0]              req_i;
    logic [NREQ-1:0]              we_i;
    logic [NREQ-1:0][ADDR_W-1:0]  addr_i;
    logic [NREQ-1:0][WORD_W-1:0]  wdata_i;
    logic [NREQ-1:0]              gnt_o;
    logic [NREQ-1:0]              done_o;
    logic [NREQ-1:0]              err_o;
    logic [WORD_W-1:0]            rdata_o;

    // Data-memory side
    logic                         mem_we_o;
    logic [ADDR_W-1:0]            mem_addr_o;
    logic [WORD_W-1:0]            mem_wd_o;
    logic [WORD_W-1:0]            mem_rd_i;

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, mem_rd_i,
        output gnt_o, done_o, err_o, rdata_o, mem_we_o, mem_addr_o, mem_wd_o
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i, mem_rd_i,
        input  gnt_o, done_o, err_o, rdata_o, mem_we_o, mem_addr_o, mem_wd_o
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter with its priority pointer.
//   clk, rst : clock, asynchronous active-high reset
//   i_req    : request vector (bit r = requester r)
//   o_gnt    : combinational one-hot grant, forced low while rst is high
// The pointer names the requester that wins the next contested cycle. After a
// contested grant it moves to the loser; uncontested grants leave it alone.
// -----------------------------------------------------------------------------
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] i_req,
    output logic [NREQ-1:0] o_gnt
);

    logic            r_prio;
    logic [NREQ-1:0] w_gnt;

    always_comb begin
        w_gnt = '0;
        if (!rst) begin
            unique case (i_req)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = id_onehot(r_prio);
                default: w_gnt = 2'b00;
            endcase
        end
    end

    assign o_gnt = w_gnt;

    // Winner of a contested cycle is r_prio, so the loser is its complement
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio <= 1'b0;
        end else if (i_req == 2'b11) begin
            r_prio <= ~r_prio;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one single-port vector data memory between the vector CPU
// load/store unit (requester 0) and an external loader (requester 1).
// One access is accepted per cycle; each runs through a two-stage pipeline:
//   accept edge      : op captured into stage S (_p1 registers)
//   cycle after      : S drives the memory port, write enable only in range
//   end of that cycle: completion, range error and read data registered
//                      (_p2 registers) and presented for exactly one cycle
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   io_bus   : dmem_arbiter_if.slave (requester ports + data-memory port)
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int LANES     = DEF_LANES,
    parameter int LANE_W    = DEF_LANE_W,
    parameter int DMEM_SIZE = DEF_DMEM_SIZE
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave io_bus
);

    localparam int                WORD_W   = LANES * LANE_W;
    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(DMEM_SIZE);

    // Address range check against the highest valid word address
    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return addr <= MAX_ADDR;
    endfunction

    // Read data is only returned for in-range reads; writes and errors give 0
    function automatic logic [WORD_W-1:0] qual_rdata(
        input logic              we,
        input logic              inr,
        input logic [WORD_W-1:0] rd
    );
        return (!we && inr) ? rd : '0;
    endfunction

    logic [NREQ-1:0]   w_gnt;
    logic              w_acc;
    logic              w_id;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [WORD_W-1:0] w_wdata;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .i_req (io_bus.req_i),
        .o_gnt (w_gnt)
    );

    assign io_bus.gnt_o = w_gnt;
    assign w_acc        = |w_gnt;
    assign w_id         = w_gnt[1];
    assign w_we         = io_bus.we_i[w_id];
    assign w_addr       = io_bus.addr_i[w_id];
    assign w_wdata      = io_bus.wdata_i[w_id];

    // ---- Stage S: accepted op, drives the memory port ----
    logic              r_vld_p1;
    logic              r_id_p1;
    logic              r_we_p1;
    logic              r_inr_p1;
    logic [ADDR_W-1:0] r_addr_p1;
    logic [WORD_W-1:0] r_wdata_p1;

    // The payload is loaded only on accept so the memory address/data hold
    // their last value while S is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1   <= 1'b0;
            r_id_p1    <= 1'b0;
            r_we_p1    <= 1'b0;
            r_inr_p1   <= 1'b0;
            r_addr_p1  <= '0;
            r_wdata_p1 <= '0;
        end else begin
            r_vld_p1 <= w_acc;
            if (w_acc) begin
                r_id_p1    <= w_id;
                r_we_p1    <= w_we;
                r_inr_p1   <= in_range(w_addr);
                r_addr_p1  <= w_addr;
                r_wdata_p1 <= w_wdata;
            end
        end
    end

    // Write enable is decoded from S; reset clears S, so an in-flight write
    // loses its enable the moment rst rises.
    assign io_bus.mem_we_o   = r_vld_p1 & r_we_p1 & r_inr_p1;
    assign io_bus.mem_addr_o = r_addr_p1;
    assign io_bus.mem_wd_o   = r_wdata_p1;

    // ---- Response stage: completion pulse, error and read data ----
    logic [NREQ-1:0]   r_done_p2;
    logic [NREQ-1:0]   r_err_p2;
    logic [WORD_W-1:0] r_rdata_p2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done_p2  <= '0;
            r_err_p2   <= '0;
            r_rdata_p2 <= '0;
        end else begin
            r_done_p2  <= r_vld_p1 ? id_onehot(r_id_p1) : '0;
            r_err_p2   <= (r_vld_p1 && !r_inr_p1) ? id_onehot(r_id_p1) : '0;
            r_rdata_p2 <= r_vld_p1 ? qual_rdata(r_we_p1, r_inr_p1, io_bus.mem_rd_i)
                                   : '0;
        end
    end

    assign io_bus.done_o  = r_done_p2;
    assign io_bus.err_o   = r_err_p2;
    assign io_bus.rdata_o = r_rdata_p2;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 17, data memory address width.
REQ-002 Parameter LANES, default 6, vector lanes per memory word.
REQ-003 Parameter LANE_W, default 8, bits per lane.
REQ-004 Parameter DMEM_SIZE, default 10926, highest valid word address (inclusive).
REQ-005 clk  input  1  single clock; all state updates on posedge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 req_i[r]  input  1 each, r=0..1  access request; r=0 vector CPU load/store unit, r=1 external loader.
REQ-008 we_i[r]  input  1 each  1 = write, 0 = read.
REQ-009 addr_i[r]  input  ADDR_W each  word address.
REQ-010 wdata_i[r]  input  LANES x LANE_W each  write vector.
REQ-011 gnt_o[r]  output  1 each  request accepted this cycle (combinational).
REQ-012 done_o[r]  output  1 each  one-cycle completion pulse.
REQ-013 err_o[r]  output  1 each  qualifies done_o; address out of range.
REQ-014 rdata_o  output  LANES x LANE_W  read vector, valid while done_o[r] of a read is high.
REQ-015 mem_we_o  output  1  data memory write enable.
REQ-016 mem_addr_o  output  ADDR_W  data memory address.
REQ-017 mem_wd_o  output  LANES x LANE_W  data memory write data.
REQ-018 mem_rd_i  input  LANES x LANE_W  data memory combinational read data.

Function
REQ-019 At most one gnt_o bit high per cycle; gnt_o[r] only when req_i[r] high; a request is accepted in the cycle gnt_o is high.
REQ-020 Single requester: granted in the same cycle, every cycle (throughput 1 access/cycle).
REQ-021 Both requesting: grant goes to requester indicated by priority pointer prio (reset 0); after each contested grant prio points to the loser.
REQ-022 Uncontested grants leave prio unchanged.
REQ-023 Accepted op (requester id, we, addr, wdata, range flag) captured into stage register S at the accept edge (cycle N).
REQ-024 Cycle N+1: S valid drives mem_addr_o=S.addr, mem_wd_o=S.wdata, mem_we_o=S.we and in-range; otherwise mem_we_o=0.
REQ-025 End of cycle N+1: mem_rd_i captured into rdata_o register; done_o[S.id] and err_o[S.id] registered.
REQ-026 Cycle N+2: done_o[id] high exactly one cycle; err_o[id]=1 iff addr > DMEM_SIZE; rdata_o holds read data for in-range reads, all-zero for writes and errors.
REQ-027 Out-of-range access: never asserts mem_we_o, still completes with done_o and err_o, no lane written.
REQ-028 Back-to-back ops pipeline: done pulses arrive in accept order, one per cycle, no bubbles.
REQ-029 Read after write to same address on consecutive accepts returns the newly written vector.
REQ-030 When S invalid: mem_we_o=0, mem_addr_o and mem_wd_o hold last value.
REQ-031 Inputs sampled only in accept cycle; requester may change them afterwards.

Reset
REQ-032 rst asserted: immediately mem_we_o=0, gnt_o=0, done_o=0, err_o=0, rdata_o=0, mem_addr_o=0, mem_wd_o=0, prio=0, S invalid.
REQ-033 Ops in flight at reset are discarded without done_o; no memory write occurs from a discarded op.
REQ-034 First grant possible in first cycle after rst deasserts.

Structure
REQ-035 Shared package holds LANES, LANE_W, ADDR_W, DMEM_SIZE defaults and the vector word typedef (LANES x LANE_W packed) used with data memory.
REQ-036 Single sub-module rr_arb2 (2-way round-robin grant plus prio register); stage and response registers live in dmem_arbiter.

Verification
REQ-037 r0 writes addr 5 data {1,2,3,4,5,6}, next cycle reads addr 5 -> mem_we_o high one cycle, read done_o[0] at accept+2 with rdata_o {1,2,3,4,5,6}.
REQ-038 Both request continuously 6 cycles from reset -> grants alternate 0,1,0,1,0,1.
REQ-039 r1 read addr 10927 -> no mem_we_o, done_o[1]=1, err_o[1]=1, rdata_o=0; addr 10926 -> err_o=0.
REQ-040 r1 alone 4 back-to-back writes addrs 0..3 -> four mem_we_o cycles, four consecutive done_o[1] pulses.
REQ-041 rst asserted mid-cycle after write accept -> mem_we_o drops at once, no done_o, memory at that address unchanged.
REQ-042 r0 requests alone 3 cycles then both request -> r0 wins first contested cycle (prio 0), r1 next.
